// File: rtl/cc_linefill_ctrl.sv
// ============================================================================
// cc_linefill_ctrl
// Miss-handling sequencer: fetches one 64-byte line as an 8-beat 64-bit AXI
// INCR read burst, assembles it in a 512-bit buffer, then writes tag + data
// into the SRAM write port in a single cycle and reports completion/error.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cc_linefill_ctrl #(
  parameter logic [3:0] ARID  = 4'd0,
  parameter int         SAT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  // miss request
  input  logic             miss_valid_i,
  output logic             miss_ready_o,
  input  logic [31:0]      miss_addr_i,
  // AXI read address channel
  output logic [3:0]       mem_arid_o,
  output logic [31:0]      mem_araddr_o,
  output logic [3:0]       mem_arlen_o,
  output logic [2:0]       mem_arsize_o,
  output logic [1:0]       mem_arburst_o,
  output logic             mem_arvalid_o,
  input  logic             mem_arready_i,
  // AXI read data channel
  input  logic [3:0]       mem_rid_i,
  input  logic [63:0]      mem_rdata_i,
  input  logic [1:0]       mem_rresp_i,
  input  logic             mem_rlast_i,
  input  logic             mem_rvalid_i,
  output logic             mem_rready_o,
  // SRAM write port
  output logic             wren_o,
  output logic [8:0]       waddr_o,
  output logic [17:0]      wdata_tag_o,
  output logic [511:0]     wdata_data_o,
  // completion / status
  output logic             fill_done_o,
  output logic             fill_err_o,
  output logic [SAT_W-1:0] fill_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2,
    S_WR   = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;

  logic [16:0]        tag_q;
  logic [8:0]         idx_q;
  logic [25:0]        blk_q;
  logic [3:0]         cnt_q;      // beats stored so far; bit 3 set means the line is full
  logic               err_q;      // sticky for the current fill
  logic [511:0]       line_q;
  logic [SAT_W-1:0]   fill_cnt_q;

  logic               miss_hs;
  logic               beat;
  logic               beat_err;
  logic               wr_cycle;
  logic               unused_addr_lsb;

  assign miss_hs  = (state == S_IDLE) && miss_valid_i;
  assign beat     = (state == S_R) && mem_rvalid_i;
  assign wr_cycle = (state == S_WR);

  // A beat poisons the fill on a bad response, a foreign ID, an rlast that is
  // not the eighth beat, or any beat beyond the eighth.
  assign beat_err = (mem_rresp_i != 2'b00) || (mem_rid_i != ARID) ||
                    (mem_rlast_i && (cnt_q != 4'd7)) || cnt_q[3];

  // Byte offset within the line is irrelevant: requests are block-aligned.
  assign unused_addr_lsb = ^miss_addr_i[5:0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (miss_valid_i)                  state_nxt = S_AR;
      S_AR:   if (mem_arready_i)                 state_nxt = S_R;
      S_R:    if (mem_rvalid_i && mem_rlast_i)   state_nxt = S_WR;
      S_WR:                                      state_nxt = S_IDLE;
      default:                                   state_nxt = S_IDLE;
    endcase
  end

  // Request capture, line assembly, error tracking and the fill counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q      <= '0;
      idx_q      <= '0;
      blk_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      line_q     <= '0;
      fill_cnt_q <= '0;
    end else begin
      if (miss_hs) begin
        tag_q  <= miss_addr_i[31:15];
        idx_q  <= miss_addr_i[14:6];
        blk_q  <= miss_addr_i[31:6];
        cnt_q  <= '0;
        err_q  <= 1'b0;
        line_q <= '0;
      end
      if (beat) begin
        if (!cnt_q[3]) begin
          line_q[{cnt_q[2:0], 6'd0} +: 64] <= mem_rdata_i;
          cnt_q                            <= cnt_q + 4'd1;
        end
        if (beat_err) begin
          err_q <= 1'b1;
        end
      end
      if (wr_cycle && !err_q && (fill_cnt_q != {SAT_W{1'b1}})) begin
        fill_cnt_q <= fill_cnt_q + SAT_W'(1);
      end
    end
  end

  // Handshake and fixed AR fields
  assign miss_ready_o  = (state == S_IDLE);
  assign mem_arvalid_o = (state == S_AR);
  assign mem_rready_o  = (state == S_R);
  assign mem_arid_o    = ARID;
  assign mem_araddr_o  = {blk_q, 6'b0};
  assign mem_arlen_o   = 4'd7;
  assign mem_arsize_o  = 3'd3;
  assign mem_arburst_o = 2'b01;

  // SRAM write and status; write fields read zero outside the WR cycle
  assign wren_o       = wr_cycle && !err_q;
  assign waddr_o      = wr_cycle ? idx_q : 9'd0;
  assign wdata_tag_o  = wr_cycle ? {1'b1, tag_q} : 18'd0;
  assign wdata_data_o = wr_cycle ? line_q : 512'd0;
  assign fill_done_o  = wr_cycle;
  assign fill_err_o   = wr_cycle && err_q;
  assign fill_cnt_o   = fill_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_cc_linefill_ctrl.sv
// ============================================================================
// tb_cc_linefill_ctrl
// Directed bench: drives miss requests and an AXI read responder cycle by
// cycle, comparing outputs against hand-computed values.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cc_linefill_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         miss_valid_i;
  logic         miss_ready_o;
  logic [31:0]  miss_addr_i;
  logic [3:0]   mem_arid_o;
  logic [31:0]  mem_araddr_o;
  logic [3:0]   mem_arlen_o;
  logic [2:0]   mem_arsize_o;
  logic [1:0]   mem_arburst_o;
  logic         mem_arvalid_o;
  logic         mem_arready_i;
  logic [3:0]   mem_rid_i;
  logic [63:0]  mem_rdata_i;
  logic [1:0]   mem_rresp_i;
  logic         mem_rlast_i;
  logic         mem_rvalid_i;
  logic         mem_rready_o;
  logic         wren_o;
  logic [8:0]   waddr_o;
  logic [17:0]  wdata_tag_o;
  logic [511:0] wdata_data_o;
  logic         fill_done_o;
  logic         fill_err_o;
  logic [15:0]  fill_cnt_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cc_linefill_ctrl #(.ARID(4'd0), .SAT_W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .miss_valid_i  (miss_valid_i),
    .miss_ready_o  (miss_ready_o),
    .miss_addr_i   (miss_addr_i),
    .mem_arid_o    (mem_arid_o),
    .mem_araddr_o  (mem_araddr_o),
    .mem_arlen_o   (mem_arlen_o),
    .mem_arsize_o  (mem_arsize_o),
    .mem_arburst_o (mem_arburst_o),
    .mem_arvalid_o (mem_arvalid_o),
    .mem_arready_i (mem_arready_i),
    .mem_rid_i     (mem_rid_i),
    .mem_rdata_i   (mem_rdata_i),
    .mem_rresp_i   (mem_rresp_i),
    .mem_rlast_i   (mem_rlast_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rready_o  (mem_rready_o),
    .wren_o        (wren_o),
    .waddr_o       (waddr_o),
    .wdata_tag_o   (wdata_tag_o),
    .wdata_data_o  (wdata_data_o),
    .fill_done_o   (fill_done_o),
    .fill_err_o    (fill_err_o),
    .fill_cnt_o    (fill_cnt_o)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] word(input logic [7:0] seed, input int b);
    return {seed, 8'(b), 16'hBEEF, 8'(b), seed, 16'h1234};
  endfunction

  // One complete fill. resp_beat / rid_beat select a beat with SLVERR / wrong
  // RID (-1 for none); last_at is the beat carrying rlast; gap_mask bit b
  // inserts an idle rvalid cycle before beat b.
  task automatic run_fill(input string nm, input logic [31:0] addr, input logic [31:0] exp_araddr,
                          input logic [8:0] exp_idx, input logic [16:0] exp_tag,
                          input int ar_wait, input logic [7:0] gap_mask,
                          input int resp_beat, input int rid_beat, input int last_at,
                          input logic exp_err, input logic [15:0] exp_cnt, input logic [7:0] seed);
    logic [511:0] exp_line;
    exp_line = '0;
    chk({nm, ".idle_ready"}, 512'(miss_ready_o), 512'd1);
    miss_valid_i  = 1'b1;
    miss_addr_i   = addr;
    mem_arready_i = (ar_wait == 0);
    step();
    miss_valid_i = 1'b0;
    miss_addr_i  = 32'hDEAD_BEEF;
    chk({nm, ".arvalid"}, 512'(mem_arvalid_o), 512'd1);
    chk({nm, ".araddr"}, 512'(mem_araddr_o), 512'(exp_araddr));
    chk({nm, ".busy_not_ready"}, 512'(miss_ready_o), 512'd0);
    if (ar_wait > 0) begin
      for (int i = 0; i < ar_wait; i++) begin
        step();
        chk({nm, ".ar_hold_valid"}, 512'(mem_arvalid_o), 512'd1);
        chk({nm, ".ar_hold_addr"}, 512'(mem_araddr_o), 512'(exp_araddr));
      end
      mem_arready_i = 1'b1;
    end
    step();
    mem_arready_i = 1'b0;
    chk({nm, ".rready"}, 512'(mem_rready_o), 512'd1);
    chk({nm, ".ar_dropped"}, 512'(mem_arvalid_o), 512'd0);
    for (int b = 0; b <= last_at; b++) begin
      if (gap_mask[b]) begin
        mem_rvalid_i = 1'b0;
        step();
        chk({nm, ".rready_gap"}, 512'(mem_rready_o), 512'd1);
      end
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = word(seed, b);
      mem_rresp_i  = (b == resp_beat) ? 2'b10 : 2'b00;
      mem_rid_i    = (b == rid_beat) ? 4'd5 : 4'd0;
      mem_rlast_i  = (b == last_at);
      if (b < 8) exp_line[64*b +: 64] = word(seed, b);
      step();
      if (b < last_at) begin
        chk({nm, ".no_done_early"}, 512'({fill_done_o, wren_o}), 512'd0);
      end
    end
    mem_rvalid_i = 1'b0;
    mem_rlast_i  = 1'b0;
    mem_rresp_i  = 2'b00;
    mem_rid_i    = 4'd0;
    chk({nm, ".done"}, 512'(fill_done_o), 512'd1);
    chk({nm, ".err"}, 512'(fill_err_o), 512'(exp_err));
    chk({nm, ".wren"}, 512'(wren_o), 512'(!exp_err));
    if (!exp_err) begin
      chk({nm, ".waddr"}, 512'(waddr_o), 512'(exp_idx));
      chk({nm, ".wtag"}, 512'(wdata_tag_o), 512'({1'b1, exp_tag}));
      chk({nm, ".wdata"}, wdata_data_o, exp_line);
    end
    step();
    chk({nm, ".done_once"}, 512'({fill_done_o, wren_o}), 512'd0);
    chk({nm, ".ready_again"}, 512'(miss_ready_o), 512'd1);
    chk({nm, ".fill_cnt"}, 512'(fill_cnt_o), 512'(exp_cnt));
  endtask

  initial begin
    rst_n         = 1'b0;
    miss_valid_i  = 1'b0;
    miss_addr_i   = '0;
    mem_arready_i = 1'b0;
    mem_rid_i     = '0;
    mem_rdata_i   = '0;
    mem_rresp_i   = '0;
    mem_rlast_i   = 1'b0;
    mem_rvalid_i  = 1'b0;
    step();
    step();

    // Reset state and constant AR fields
    chk("rst.miss_ready", 512'(miss_ready_o), 512'd1);
    chk("rst.ctrl", 512'({mem_arvalid_o, mem_rready_o, wren_o, fill_done_o, fill_err_o}), 512'd0);
    chk("rst.fill_cnt", 512'(fill_cnt_o), 512'd0);
    chk("rst.wfields", 512'({waddr_o, wdata_tag_o}), 512'd0);
    chk("rst.wdata", wdata_data_o, 512'd0);
    chk("rst.ar_const", 512'({mem_arid_o, mem_arlen_o, mem_arsize_o, mem_arburst_o}),
        512'({4'd0, 4'd7, 3'd3, 2'b01}));
    rst_n = 1'b1;
    step();

    // Basic fill, zero-latency memory
    run_fill("f1", 32'h0000_1A40, 32'h0000_1A40, 9'h069, 17'h00000, 0, 8'h00, -1, -1, 7, 1'b0, 16'd1, 8'h11);
    // Unaligned address, top index
    run_fill("f2", 32'h0000_FFFF, 32'h0000_FFC0, 9'h1FF, 17'h00001, 0, 8'h00, -1, -1, 7, 1'b0, 16'd2, 8'h22);
    // arready held low 5 cycles, rvalid gaps
    run_fill("f3", 32'h1234_5680, 32'h1234_5680, 9'h15A, 17'h02468, 5, 8'b1010_0101, -1, -1, 7, 1'b0, 16'd3, 8'h33);
    // SLVERR on beat 3: all beats consumed, no write
    run_fill("f4", 32'h0000_2000, 32'h0000_2000, 9'h080, 17'h00000, 0, 8'h00, 3, -1, 7, 1'b1, 16'd3, 8'h44);
    // Early rlast on beat 5
    run_fill("f5", 32'h0000_3000, 32'h0000_3000, 9'h0C0, 17'h00000, 0, 8'h00, -1, -1, 5, 1'b1, 16'd3, 8'h55);
    // Clean fill right after an error
    run_fill("f6", 32'hFFFF_8040, 32'hFFFF_8040, 9'h001, 17'h1FFFF, 0, 8'h00, -1, -1, 7, 1'b0, 16'd4, 8'h66);
    // Wrong RID on beat 6
    run_fill("f7", 32'h0000_4000, 32'h0000_4000, 9'h100, 17'h00000, 0, 8'h00, -1, 6, 7, 1'b1, 16'd4, 8'h77);

    // Reset after beat 4 of a fill
    miss_valid_i  = 1'b1;
    miss_addr_i   = 32'h0000_5000;
    mem_arready_i = 1'b1;
    step();
    miss_valid_i = 1'b0;
    step();
    mem_arready_i = 1'b0;
    for (int b = 0; b < 4; b++) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = word(8'h88, b);
      step();
    end
    mem_rvalid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst.miss_ready", 512'(miss_ready_o), 512'd1);
    chk("mid_rst.ctrl", 512'({mem_arvalid_o, mem_rready_o, wren_o, fill_done_o, fill_err_o}), 512'd0);
    chk("mid_rst.fill_cnt", 512'(fill_cnt_o), 512'd0);
    chk("mid_rst.wdata", wdata_data_o, 512'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("mid_rst.no_done", 512'({fill_done_o, wren_o}), 512'd0);
    run_fill("f8", 32'h0000_1A7F, 32'h0000_1A40, 9'h069, 17'h00000, 0, 8'b0100_0010, -1, -1, 7, 1'b0, 16'd1, 8'h99);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/cc_linefill_ctrl.md
# cc_linefill_ctrl

Miss-handling sequencer for the cache controller. It accepts one block-aligned miss request at a time and fetches the 64-byte line from memory as one 8-beat, 64-bit AXI INCR read burst. It assembles the line in a 512-bit buffer and writes tag and data into the dual-port SRAM write port in a single cycle. It then reports completion, with error status, back to the controller's lookup logic.

## Interface
Parameters:
- ARID, default 4'd0: constant driven on mem_arid_o; also the only accepted RID.
- SAT_W, default 16: width of the fill counter.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- miss_valid_i  input  1  miss request valid.
- miss_ready_o  output  1  miss request accepted when both valid and ready are high.
- miss_addr_i  input  32  miss byte address; tag = [31:15], index = [14:6]; bits [5:0] are ignored (forced to 0).
- mem_arid_o  output  4  equals ARID.
- mem_araddr_o  output  32  {miss_addr[31:6], 6'b0}.
- mem_arlen_o  output  4  constant 4'd7.
- mem_arsize_o  output  3  constant 3'd3.
- mem_arburst_o  output  2  constant 2'b01 (INCR).
- mem_arvalid_o  output  1  read address valid.
- mem_arready_i  input  1  read address ready.
- mem_rid_i  input  4  read ID.
- mem_rdata_i  input  64  read data beat.
- mem_rresp_i  input  2  read response; 2'b00 is OKAY.
- mem_rlast_i  input  1  last beat of the burst.
- mem_rvalid_i  input  1  read data valid.
- mem_rready_o  output  1  read data ready.
- wren_o  output  1  SRAM write enable, one-cycle pulse.
- waddr_o  output  9  SRAM write index.
- wdata_tag_o  output  18  {valid=1'b1, tag[16:0]}.
- wdata_data_o  output  512  assembled line.
- fill_done_o  output  1  one-cycle completion pulse.
- fill_err_o  output  1  qualified by fill_done_o; 1 means the line was not written.
- fill_cnt_o  output  SAT_W  count of successful fills; saturates at all-ones.

## Operation
The block is a state machine with four states: IDLE, AR, R, WR.

- IDLE
  - miss_ready_o = 1.
  - On handshake: latch tag, index and aligned address; clear the beat counter, the error flag and the line buffer; go to AR.
- AR
  - mem_arvalid_o = 1, address fields stable.
  - On mem_arready_i: go to R.
  - arvalid never drops before the handshake.
- R
  - mem_rready_o = 1.
  - Each beat (rvalid & rready) with beat count cnt < 8: line[64*cnt +: 64] = rdata; cnt increments.
  - Beats arriving when cnt ≥ 8 are accepted and discarded; error set.
  - Error is set on any of: rresp != 0, rid != ARID, rlast on a beat with cnt != 7, or a beat arriving at cnt ≥ 8.
  - The error flag is sticky for the current fill.
  - On a beat with rlast: go to WR.
- WR (one cycle)
  - fill_done_o = 1 and fill_err_o = error flag.
  - If no error: wren_o = 1, waddr_o = index, wdata_tag_o = {1'b1, tag}, wdata_data_o = line; fill_cnt_o increments, saturating.
  - If error: wren_o = 0; SRAM contents are unchanged.
  - Next state: IDLE.
- Only one fill is outstanding at a time; no new AR is issued until the current fill's WR cycle has completed.

## Timing
- Reset (asynchronous, on rst_n low):
  - State = IDLE.
  - miss_ready_o = 1.
  - mem_arvalid_o, mem_rready_o, wren_o, fill_done_o and fill_err_o = 0.
  - fill_cnt_o = 0; waddr_o, wdata_tag_o and wdata_data_o = 0.
  - The constant AR fields hold their fixed values.
- Reset mid-fill: any partial line is discarded with no SRAM write and no fill_done_o pulse. An AXI burst left outstanding is the memory side's responsibility.
- Latency, miss handshake at edge N with arready already high:
  - arvalid high in cycle N+1; AR handshake at edge N+1.
  - rready high from cycle N+2.
  - With back-to-back beats, the last beat is taken at edge N+9; wren_o and fill_done_o are high in cycle N+10.
  - miss_ready_o is high again in cycle N+11.
- Minimum turnaround: 11 cycles per miss.
- rready is high throughout R; a gap in rvalid only stalls the beat counter.
- wren_o asserts only in WR and only when the error flag is clear. rden_o is not driven by this block.
- fill_done_o and wren_o assert in the same cycle. The controller may issue the SRAM read for the filled index from the following cycle.

## Test plan
- Miss at 0x0000_1A40, memory zero-latency, all responses OKAY:
  - araddr = 0x0000_1A40, arlen = 7, arsize = 3, arburst = 01.
  - After 8 beats: wren_o for 1 cycle with waddr = 0x069 and wdata_tag = {1'b1, 17'h00000}.
  - wdata_data equals the 8 memory words in ascending order; fill_err_o = 0; fill_cnt_o = 1.
- Miss at 0x0000_FFFF:
  - araddr = 0x0000_FFC0, waddr = 0x1FF, tag = 17'h00001.
- arready held low for 5 cycles, then random rvalid gaps:
  - arvalid and araddr remain stable until the handshake.
  - The line is assembled correctly; fill_done_o is asserted exactly once.
- rresp = SLVERR on beat 3:
  - All 8 beats are consumed; fill_done_o = 1 with fill_err_o = 1.
  - No wren_o; fill_cnt_o is unchanged.
- rlast on beat 5:
  - fill_err_o = 1, no write, back to IDLE.
  - A following miss completes cleanly.
- rst_n low for 1 cycle after beat 4 of a fill:
  - Outputs return to reset values immediately; no wren_o and no fill_done_o.
  - A subsequent miss fills correctly.
